// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Time-multiplexed scan controller for a multi-digit seven-segment
//            display with a shared registered BCD decoder, valid/ready load
//            handshake, frame-synchronous display update and leading-zero /
//            invalid-code blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int GUARD_CYCLES  = 2,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              number_out,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int SW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);

    localparam logic [SW-1:0] c_slot_last  = SW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] c_cnt_last   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] c_guard_last = CW'(GUARD_CYCLES - 1);

    typedef enum logic [0:0] {
        S_GUARD = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SW-1:0]           r_slot;
    logic [SW-1:0]           w_slot_nxt;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [4*NUM_DIGITS-1:0] w_disp_nxt;
    logic                    r_pend_vld;
    logic [3:0]              r_number;
    logic                    w_frame_end;
    logic                    w_xfer;
    logic [3:0]              w_cur_dig [NUM_DIGITS];
    logic [3:0]              w_nxt_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_above_zero;
    logic [3:0]              w_nxt_code;

    // Pending word moves to the display at the frame boundary, or at once while
    // scanning is disabled (nothing is on screen, so no tearing is possible).
    assign w_frame_end = en && (r_slot == c_slot_last) && (r_cnt == c_cnt_last);
    assign w_xfer      = r_pend_vld && (!en || w_frame_end);
    assign w_disp_nxt  = w_xfer ? r_pend : r_disp;
    assign w_nxt_code  = w_nxt_dig[w_slot_nxt];

    assign load_ready  = !r_pend_vld;
    assign number_out  = r_number;

    // Split display words into digits; walk from the top to find leading zeros.
    always_comb begin
        w_above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_cur_dig[i] = r_disp[4*i +: 4];
            w_nxt_dig[i] = w_disp_nxt[4*i +: 4];
            w_blank[i]   = (w_cur_dig[i] > 4'd9) ||
                           ((BLANK_LEADING != 0) && (i != 0) && w_above_zero &&
                            (w_cur_dig[i] == 4'd0));
            w_above_zero = w_above_zero && (w_cur_dig[i] == 4'd0);
        end
    end

    // Scan FSM next state and anode drive; anodes are only lit in SHOW.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_cnt_nxt   = r_cnt + 1'b1;
        digit_en    = '1;
        if (!en) begin
            w_state_nxt = S_GUARD;
            w_slot_nxt  = '0;
            w_cnt_nxt   = '0;
        end else if (r_state == S_GUARD) begin
            if (r_cnt == c_guard_last) begin
                w_state_nxt = S_SHOW;
            end
        end else begin
            if (r_cnt == c_cnt_last) begin
                w_state_nxt = S_GUARD;
                w_cnt_nxt   = '0;
                w_slot_nxt  = (r_slot == c_slot_last) ? '0 : r_slot + 1'b1;
            end
        end
        if ((r_state == S_SHOW) && !w_blank[r_slot]) begin
            digit_en[r_slot] = 1'b0;
        end
    end

    // Scan position and FSM state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_GUARD;
            r_slot  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Load handshake: capture into pending, then hand over to the display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_disp <= w_disp_nxt;
            if (w_xfer) begin
                r_pend_vld <= 1'b0;
            end else if (load && !r_pend_vld) begin
                r_pend     <= load_data;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Decoder code latched as each slot begins so the decoder output settles
    // during guard time; invalid codes are sent as 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_number <= 4'd0;
        end else if (w_cnt_nxt == '0) begin
            r_number <= (w_nxt_code > 4'd9) ? 4'd0 : w_nxt_code;
        end
    end

endmodule
`default_nettype wire
